game_flow_ctrl: RTL and testbench

//  Top-level game sequencer for breakout with lives and levels: startup, serve, play,

---
 rtl/game_pkg.sv | 51 +++++
 rtl/key_edge.sv | 27 ++
 rtl/game_flow_ctrl.sv | 158 +++++++++++++++
 tb/tb_game_flow_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared breakout sequencer types: FSM states and renderer screen codes.
// GAME_PAUSE_EN adds the PAUSE state and its screen mapping.
package game_pkg;

    localparam int LIVES_W = 4;
    localparam int LEVEL_W = 4;

    localparam logic [2:0] SCR_START = 3'd0;
    localparam logic [2:0] SCR_OVER  = 3'd1;
    localparam logic [2:0] SCR_PLAY  = 3'd2;
    localparam logic [2:0] SCR_CLEAR = 3'd3;
    localparam logic [2:0] SCR_WIN   = 3'd4;
    localparam logic [2:0] SCR_PAUSE = 3'd5;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_START,
        ST_SERVE,
        ST_PLAY,
        ST_LIFE_LOST,
        ST_LEVEL_CLEAR,
        ST_OVER,
        ST_WIN
`ifdef GAME_PAUSE_EN
        , ST_PAUSE
`endif
    } state_t;

    function automatic logic [2:0] screen_of(state_t s);
        case (s)
            ST_SERVE, ST_PLAY, ST_LIFE_LOST: screen_of = SCR_PLAY;
            ST_LEVEL_CLEAR:                  screen_of = SCR_CLEAR;
            ST_OVER:                         screen_of = SCR_OVER;
            ST_WIN:                          screen_of = SCR_WIN;
`ifdef GAME_PAUSE_EN
            ST_PAUSE:                        screen_of = SCR_PAUSE;
`endif
            default:                         screen_of = SCR_START;
        endcase
    endfunction

    // States whose screen the renderer draws and acknowledges with screen_done.
    function automatic logic is_drawn(state_t s);
        is_drawn = (s == ST_START) || (s == ST_OVER) || (s == ST_WIN)
`ifdef GAME_PAUSE_EN
                   || (s == ST_PAUSE)
`endif
                   ;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Active-low push-button synchroniser with a single-cycle press pulse.
// Used for play_game and, under GAME_PAUSE_EN, pause_key.
module key_edge (
    input  logic clock,
    input  logic reset_game_control,
    input  logic key_n_i,
    output logic press_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clock or negedge reset_game_control) begin
        if (!reset_game_control) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= key_n_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // A held key leaves prev_q low, so it never fires again until released.
    assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Breakout game sequencer: lives, levels, banner holds and renderer handshake.
// Define GAME_PAUSE_EN to add the pause screen driven by pause_key.
import game_pkg::*;

module game_flow_ctrl #(
    parameter int NUM_LIVES   = 3,
    parameter int NUM_LEVELS  = 4,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic       clock,
    input  logic       reset_game_control,
    input  logic       play_game,
    input  logic       pause_key,
    input  logic       ball_down,
    input  logic       all_bricks_down,
    input  logic       screen_done,
    output logic       screen_start,
    output logic       plot,
    output logic [2:0] sel_screen,
    output logic       run_game,
    output logic       reset_control,
    output logic       reset_brick_count,
    output logic       enable_brick_count,
    output logic [3:0] lives_left,
    output logic [3:0] level
);

    localparam int                 CNT_W      = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               entering, holding, hold_last;
    logic               play_press;
    logic               screen_start_q, plot_q, run_q, en_q, rc_q, rb_q;
    logic [2:0]         sel_q;

    key_edge u_play_key (
        .clock              (clock),
        .reset_game_control (reset_game_control),
        .key_n_i            (play_game),
        .press_o            (play_press)
    );

`ifdef GAME_PAUSE_EN
    logic pause_press;

    key_edge u_pause_key (
        .clock              (clock),
        .reset_game_control (reset_game_control),
        .key_n_i            (pause_key),
        .press_o            (pause_press)
    );
`else
    logic unused_pause;
    assign unused_pause = pause_key;
`endif

    assign hold_last = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_START;
                lives_d = LIVES_INIT;
                level_d = '0;
            end
            ST_START: if (done_q && play_press) state_d = ST_SERVE;
            ST_SERVE: state_d = ST_PLAY;
            ST_PLAY: begin
                if (ball_down) begin
                    state_d = ST_LIFE_LOST;
                    lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
                end else if (all_bricks_down) begin
                    state_d = ST_LEVEL_CLEAR;
                end
`ifdef GAME_PAUSE_EN
                else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
            ST_LIFE_LOST: if (hold_last) state_d = (lives_q == '0) ? ST_OVER : ST_SERVE;
            ST_LEVEL_CLEAR: begin
                if (hold_last) begin
                    if (level_q >= LEVEL_LAST) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_SERVE;
                        level_d = level_q + 1'b1;
                    end
                end
            end
            ST_OVER, ST_WIN: if (done_q && play_press) state_d = ST_INIT;
`ifdef GAME_PAUSE_EN
            ST_PAUSE: if (done_q && pause_press) state_d = ST_PLAY;
`endif
            default: state_d = ST_INIT;
        endcase

        // Counter and screen-done flag restart on every state entry.
        entering = (state_d != state_q);
        holding  = (state_q == ST_LIFE_LOST) || (state_q == ST_LEVEL_CLEAR);
        cnt_d    = (entering || !holding) ? '0 : cnt_q + 1'b1;
        done_d   = entering ? 1'b0 : (done_q | screen_done);
    end

    // Outputs are decoded from next-state so they line up with state_q.
    always_ff @(posedge clock or negedge reset_game_control) begin
        if (!reset_game_control) begin
            state_q        <= ST_INIT;
            lives_q        <= LIVES_INIT;
            level_q        <= '0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            screen_start_q <= 1'b0;
            plot_q         <= 1'b0;
            sel_q          <= SCR_START;
            run_q          <= 1'b0;
            en_q           <= 1'b0;
            rc_q           <= 1'b0;
            rb_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
            screen_start_q <= is_drawn(state_d) && entering;
            plot_q         <= is_drawn(state_d) && !done_d;
            sel_q          <= screen_of(state_d);
            run_q          <= (state_d == ST_PLAY);
            en_q           <= (state_d == ST_PLAY);
            rc_q           <= !((state_d == ST_INIT) || (state_d == ST_SERVE));
            rb_q           <= !((state_d == ST_INIT) ||
                                ((state_d == ST_LEVEL_CLEAR) && (cnt_d == HOLD_LAST)));
        end
    end

    assign screen_start       = screen_start_q;
    assign plot               = plot_q;
    assign sel_screen         = sel_q;
    assign run_game           = run_q;
    assign enable_brick_count = en_q;
    assign reset_control      = rc_q;
    assign reset_brick_count  = rb_q;
    assign lives_left         = lives_q;
    assign level              = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: expectations are queued as stimulus is
// driven and popped against DUT outputs once the targeted state is reached.
module tb_game_flow_ctrl;

    localparam int W_RUN = 0;
    localparam int W_SEL = 1;

    logic       clock = 1'b0;
    logic       reset_game_control, play_game, pause_key, ball_down, all_bricks_down, screen_done;
    logic       screen_start, plot, run_game, reset_control, reset_brick_count, enable_brick_count;
    logic [2:0] sel_screen;
    logic [3:0] lives_left, level;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   ss_cnt = 0;
    int   rc_cnt = 0;
    int   ss0, rc0, n, rb, last;

    always #5 clock = ~clock;

    game_flow_ctrl #(.NUM_LIVES(3), .NUM_LEVELS(2), .HOLD_CYCLES(4)) dut (
        .clock              (clock),
        .reset_game_control (reset_game_control),
        .play_game          (play_game),
        .pause_key          (pause_key),
        .ball_down          (ball_down),
        .all_bricks_down    (all_bricks_down),
        .screen_done        (screen_done),
        .screen_start       (screen_start),
        .plot               (plot),
        .sel_screen         (sel_screen),
        .run_game           (run_game),
        .reset_control      (reset_control),
        .reset_brick_count  (reset_brick_count),
        .enable_brick_count (enable_brick_count),
        .lives_left         (lives_left),
        .level              (level)
    );

    always @(negedge clock) begin
        if (reset_game_control) begin
            if (screen_start) ss_cnt++;
            if (!reset_control) rc_cnt++;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input int act);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_underflow", act, -1);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, act, e.val);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    task automatic press(input bit use_pause);
        if (use_pause) pause_key = 1'b0;
        else           play_game = 1'b0;
        tick(3);
        pause_key = 1'b1;
        play_game = 1'b1;
    endtask

    task automatic screen_ack();
        screen_done = 1'b1;
        tick(1);
        screen_done = 1'b0;
    endtask

    function automatic int sig(input int which);
        if (which == W_RUN) return int'(run_game);
        return int'(sel_screen);
    endfunction

    task automatic wait_for(input string tag, input int which, input int val, input int budget);
        int k;
        k = 0;
        while (sig(which) != val && k < budget) begin
            tick(1);
            k++;
        end
        if (sig(which) != val) chk({tag, "_timeout"}, sig(which), val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_game_control = 1'b0;
        play_game = 1'b1;
        pause_key = 1'b1;
        ball_down = 1'b0;
        all_bricks_down = 1'b0;
        screen_done = 1'b0;
        tick(2);
        sb_push("rst_sel", 0);   sb_push("rst_rc", 0);  sb_push("rst_rb", 0);
        sb_push("rst_lives", 3); sb_push("rst_lvl", 0); sb_push("rst_plot", 0);
        sb_push("rst_run", 0);
        sb_pop(sel_screen); sb_pop(reset_control); sb_pop(reset_brick_count);
        sb_pop(lives_left); sb_pop(level); sb_pop(plot); sb_pop(run_game);

        // Startup screen, acknowledge, then serve into play.
        ss0 = ss_cnt;
        reset_game_control = 1'b1;
        tick(1);
        sb_push("t1_sel", 0); sb_push("t1_plot", 1);
        sb_pop(sel_screen); sb_pop(plot);
        tick(8);
        screen_ack();
        sb_push("t1_plot_done", 0);
        sb_pop(plot);
        rc0 = rc_cnt;
        sb_push("t1_ss_pulses", 1); sb_push("t1_rc_low", 1);
        sb_push("t1_rb", 1);        sb_push("t1_en", 1);
        press(0);
        wait_for("t1_play", W_RUN, 1, 10);
        tick(1);
        sb_pop(ss_cnt - ss0); sb_pop(rc_cnt - rc0);
        sb_pop(reset_brick_count); sb_pop(enable_brick_count);

        // Ball lost and wall cleared together: ball loss wins.
        sb_push("t3_lives", 2); sb_push("t3_level", 0); sb_push("t3_run", 0);
        ball_down = 1'b1;
        all_bricks_down = 1'b1;
        tick(1);
        ball_down = 1'b0;
        all_bricks_down = 1'b0;
        sb_pop(lives_left); sb_pop(level); sb_pop(run_game);
        rc0 = rc_cnt;
        n = 0;
        sb_push("t3_hold_plus_serve", 5); sb_push("t3_rc_low", 1); sb_push("t3_level_kept", 0);
        while (!run_game && n < 30) begin
            n++;
            tick(1);
        end
        sb_pop(n); sb_pop(rc_cnt - rc0); sb_pop(level);

        // Two level clears: level 0 -> 1, then WIN.
        for (int k = 0; k < 2; k++) begin
            sb_push("t4_hold", 4); sb_push("t4_rb_low", 1); sb_push("t4_rb_last", 1);
            all_bricks_down = 1'b1;
            tick(1);
            all_bricks_down = 1'b0;
            n = 0;
            rb = 0;
            last = 0;
            while (sel_screen == 3'd3 && n < 20) begin
                n++;
                rb += int'(!reset_brick_count);
                last = int'(!reset_brick_count);
                tick(1);
            end
            sb_pop(n); sb_pop(rb); sb_pop(last);
            if (k == 0) begin
                sb_push("t4_level", 1); sb_push("t4_serve_sel", 2); sb_push("t4_lives", 2);
                sb_pop(level); sb_pop(sel_screen); sb_pop(lives_left);
                wait_for("t4_play", W_RUN, 1, 10);
            end else begin
                sb_push("t4_win_sel", 4); sb_push("t4_level_sat", 1); sb_push("t4_win_plot", 1);
                sb_pop(sel_screen); sb_pop(level); sb_pop(plot);
            end
        end
        screen_ack();
        sb_push("t4_init_rc", 0); sb_push("t4_init_rb", 0);
        press(0);
        sb_pop(reset_control); sb_pop(reset_brick_count);
        tick(1);
        sb_push("t4_lives_reload", 3); sb_push("t4_level_reload", 0); sb_push("t4_start_plot", 1);
        sb_pop(lives_left); sb_pop(level); sb_pop(plot);

        // Key held from before screen_done must not start play.
        sb_push("t5_sel", 0); sb_push("t5_run", 0); sb_push("t5_run_held", 0);
        play_game = 1'b0;
        tick(6);
        sb_pop(sel_screen); sb_pop(run_game);
        screen_ack();
        tick(4);
        sb_pop(run_game);
        play_game = 1'b1;
        tick(3);
        sb_push("t5_run_fresh", 1);
        press(0);
        wait_for("t5_play", W_RUN, 1, 10);
        sb_pop(run_game);

        // Three lost balls end the game.
        for (int i = 0; i < 3; i++) begin
            sb_push("t2_lives", 2 - i);
            ball_down = 1'b1;
            tick(1);
            ball_down = 1'b0;
            sb_pop(lives_left);
            if (i < 2) wait_for("t2_reserve", W_RUN, 1, 20);
            else       wait_for("t2_over", W_SEL, 1, 20);
        end
        sb_push("t2_over_sel", 1); sb_push("t2_over_plot", 1);
        sb_pop(sel_screen); sb_pop(plot);
        screen_ack();
        press(0);
        tick(1);
        sb_push("t2_lives_reload", 3);
        sb_pop(lives_left);
        screen_ack();
        press(0);
        wait_for("t2_play", W_RUN, 1, 10);

`ifdef GAME_PAUSE_EN
        sb_push("t6_sel", 5); sb_push("t6_run", 0); sb_push("t6_en", 0); sb_push("t6_plot", 1);
        press(1);
        sb_pop(sel_screen); sb_pop(run_game); sb_pop(enable_brick_count); sb_pop(plot);
        sb_push("t6_lives", 3); sb_push("t6_sel_held", 5);
        ball_down = 1'b1;
        tick(3);
        ball_down = 1'b0;
        sb_pop(lives_left); sb_pop(sel_screen);
        screen_ack();
        sb_push("t6_resume_run", 1); sb_push("t6_resume_sel", 2);
        press(1);
        sb_pop(run_game); sb_pop(sel_screen);
        sb_push("t6_pause2", 5);
        press(1);
        sb_pop(sel_screen);
        #2 reset_game_control = 1'b0;
        #1;
        sb_push("t6_rst_sel", 0); sb_push("t6_rst_run", 0);
        sb_push("t6_rst_rc", 0);  sb_push("t6_rst_plot", 0);
        sb_pop(sel_screen); sb_pop(run_game); sb_pop(reset_control); sb_pop(plot);
        tick(1);
        reset_game_control = 1'b1;
        tick(1);
        sb_push("t6_restart_plot", 1);
        sb_pop(plot);
`else
        sb_push("t6_nopause_sel", 2); sb_push("t6_nopause_run", 1);
        press(1);
        tick(1);
        sb_pop(sel_screen); sb_pop(run_game);
`endif

        chk("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
